// File: rtl/signed_acc_pkg.sv
// -----------------------------------------------------------------------------
// signed_acc_pkg
// Shared definitions for the signed saturating accumulator:
//   WIDTH      - default width of the upstream two's-complement sum
//   ACC_WIDTH  - default accumulator width (must be >= WIDTH+2)
//   ACC_MAX/MIN- signed limits of a default-width accumulator
//   true_value - rebuilds the exact WIDTH+1-bit result of an upstream add
//                from its wrapped sum and overflow flag
// -----------------------------------------------------------------------------
package signed_acc_pkg;

    localparam int WIDTH     = 4;
    localparam int ACC_WIDTH = 8;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // On overflow the wrapped sum has the wrong sign bit; the true sign is
    // its inverse, so prepending ~msb recovers the exact value.
    function automatic logic [WIDTH:0] true_value(input logic [WIDTH-1:0] sum,
                                                  input logic             ovf);
        logic [WIDTH:0] t;
        if (ovf) begin
            t = {~sum[WIDTH-1], sum};
        end else begin
            t = {sum[WIDTH-1], sum};
        end
        return t;
    endfunction

endpackage

// File: rtl/signed_sat_add.sv
// -----------------------------------------------------------------------------
// signed_sat_add
// Combinational signed add of an ACC_WIDTH accumulator and a WIDTH+1-bit
// operand, with limit handling selected by the ACC_SATURATE_EN macro:
//   defined   : result clamps to the signed max/min, limit_o flags a clamp
//   undefined : result wraps to ACC_WIDTH bits, limit_o flags the wrap
// Ports:
//   acc_i   [ACC_WIDTH-1:0] current accumulator (signed)
//   val_i   [WIDTH:0]       operand to add (signed)
//   res_o   [ACC_WIDTH-1:0] new accumulator value
//   limit_o                 result did not fit ACC_WIDTH signed bits
// -----------------------------------------------------------------------------
module signed_sat_add
    import signed_acc_pkg::*;
#(
    parameter int W  = 4,
    parameter int AW = 8
) (
    input  logic [AW-1:0] acc_i,
    input  logic [W:0]    val_i,
    output logic [AW-1:0] res_o,
    output logic          limit_o
);

    localparam logic [AW-1:0] MAX_V = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] MIN_V = {1'b1, {(AW-1){1'b0}}};

    logic [AW:0] sum_s;
    logic        wrap_s;

    // Full-precision sum; the operand is sign-extended to the accumulator width.
    assign sum_s = {acc_i[AW-1], acc_i} + {{(AW-W){val_i[W]}}, val_i};

    // Overflow only when both operands share a sign and the truncated result
    // does not.
    assign wrap_s = (acc_i[AW-1] == val_i[W]) && (sum_s[AW-1] != acc_i[AW-1]);

    // Select clamped or wrapped result and raise the limit flag.
    always_comb begin
        res_o   = sum_s[AW-1:0];
        limit_o = wrap_s;
`ifdef ACC_SATURATE_EN
        if (wrap_s) begin
            // Direction follows the common operand sign.
            if (acc_i[AW-1]) begin
                res_o = MIN_V;
            end else begin
                res_o = MAX_V;
            end
        end else begin
            res_o = sum_s[AW-1:0];
        end
`endif
    end

endmodule

// File: rtl/signed_sat_accumulator.sv
// -----------------------------------------------------------------------------
// signed_sat_accumulator
// Consumes (sum, overflow) beats from a WIDTH-bit signed adder, rebuilds each
// beat's exact value and adds it into a signed ACC_WIDTH accumulator. The
// running total is presented over a valid/ready handshake with latency 1.
// Optional macro ACC_SATURATE_EN: clamp at the accumulator limits (default
// build wraps and only flags the wrap).
// Ports:
//   clk, rst_n (async active-low), clear (sync, highest priority)
//   up_valid/up_ready, up_sum[WIDTH-1:0], up_overflow : input beat
//   down_valid/down_ready                              : output handshake
//   acc[ACC_WIDTH-1:0]  running total
//   acc_sat             last accepted beat hit the limit
//   ovf_cnt[CNT_WIDTH-1:0] accepted beats with up_overflow=1 (saturating)
//   sticky_ovf          any limit event since clear/reset
// -----------------------------------------------------------------------------
module signed_sat_accumulator #(
    parameter int WIDTH     = signed_acc_pkg::WIDTH,
    parameter int ACC_WIDTH = signed_acc_pkg::ACC_WIDTH,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [WIDTH-1:0]     up_sum,
    input  logic                 up_overflow,
    output logic                 down_valid,
    input  logic                 down_ready,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 acc_sat,
    output logic [CNT_WIDTH-1:0] ovf_cnt,
    output logic                 sticky_ovf
);

    import signed_acc_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 acc_sat_q, acc_sat_d;
    logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
    logic                 sticky_q, sticky_d;
    logic                 down_valid_q, down_valid_d;

    logic [WIDTH:0]       true_s;
    logic [ACC_WIDTH-1:0] sum_res_s;
    logic                 limit_s;
    logic                 accept_s;

    // Single output register, no skid: a slot frees up when it is being drained.
    assign up_ready = !down_valid_q || down_ready;
    assign accept_s = up_valid && up_ready;

    generate
        if (WIDTH == signed_acc_pkg::WIDTH) begin : g_pkg_tv
            assign true_s = true_value(up_sum, up_overflow);
        end else begin : g_gen_tv
            assign true_s = {up_overflow ? ~up_sum[WIDTH-1] : up_sum[WIDTH-1], up_sum};
        end
    endgenerate

    signed_sat_add #(
        .W  (WIDTH),
        .AW (ACC_WIDTH)
    ) u_add (
        .acc_i   (acc_q),
        .val_i   (true_s),
        .res_o   (sum_res_s),
        .limit_o (limit_s)
    );

    // Next-state: clear beats everything, then accept, then drain.
    always_comb begin
        acc_d        = acc_q;
        acc_sat_d    = acc_sat_q;
        ovf_cnt_d    = ovf_cnt_q;
        sticky_d     = sticky_q;
        down_valid_d = down_valid_q;
        if (clear) begin
            // A beat accepted this cycle still handshakes but is dropped.
            acc_d        = '0;
            acc_sat_d    = 1'b0;
            ovf_cnt_d    = '0;
            sticky_d     = 1'b0;
            down_valid_d = 1'b0;
        end else if (accept_s) begin
            acc_d        = sum_res_s;
            acc_sat_d    = limit_s;
            sticky_d     = sticky_q | limit_s;
            down_valid_d = 1'b1;
            if (up_overflow && !(&ovf_cnt_q)) begin
                ovf_cnt_d = ovf_cnt_q + CNT_ONE;
            end else begin
                ovf_cnt_d = ovf_cnt_q;
            end
        end else if (down_ready) begin
            down_valid_d = 1'b0;
        end else begin
            down_valid_d = down_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            acc_sat_q    <= 1'b0;
            ovf_cnt_q    <= '0;
            sticky_q     <= 1'b0;
            down_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_sat_q    <= acc_sat_d;
            ovf_cnt_q    <= ovf_cnt_d;
            sticky_q     <= sticky_d;
            down_valid_q <= down_valid_d;
        end
    end

    assign acc        = acc_q;
    assign acc_sat    = acc_sat_q;
    assign ovf_cnt    = ovf_cnt_q;
    assign sticky_ovf = sticky_q;
    assign down_valid = down_valid_q;

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// -----------------------------------------------------------------------------
// tb_signed_sat_accumulator
// Directed vectors with hand-computed expectations for signed_sat_accumulator
// (WIDTH=4, ACC_WIDTH=8, CNT_WIDTH=8).
// -----------------------------------------------------------------------------
module tb_signed_sat_accumulator;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       up_valid;
    logic       up_ready;
    logic [3:0] up_sum;
    logic       up_overflow;
    logic       down_valid;
    logic       down_ready;
    logic [7:0] acc;
    logic       acc_sat;
    logic [7:0] ovf_cnt;
    logic       sticky_ovf;

    int n_checks;
    int n_errors;

    signed_sat_accumulator #(
        .WIDTH     (4),
        .ACC_WIDTH (8),
        .CNT_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .up_sum      (up_sum),
        .up_overflow (up_overflow),
        .down_valid  (down_valid),
        .down_ready  (down_ready),
        .acc         (acc),
        .acc_sat     (acc_sat),
        .ovf_cnt     (ovf_cnt),
        .sticky_ovf  (sticky_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [3:0] s, input logic o);
        up_valid    = 1'b1;
        up_sum      = s;
        up_overflow = o;
        step();
        up_valid    = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    logic [7:0] exp_wrap16;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        clear       = 1'b0;
        up_valid    = 1'b0;
        up_sum      = 4'h0;
        up_overflow = 1'b0;
        down_ready  = 1'b1;
`ifdef ACC_SATURATE_EN
        exp_wrap16 = 8'h7F;
`else
        exp_wrap16 = 8'h80;
`endif

        // Reset values
        #1;
        check_eq("rst_acc", acc, 8'h00);
        check_eq("rst_dv", down_valid, 1'b0);
        check_eq("rst_cnt", ovf_cnt, 8'h00);
        check_eq("rst_sticky", sticky_ovf, 1'b0);
        check_eq("rst_sat", acc_sat, 1'b0);
        #11;
        rst_n = 1'b1;
        step();
        check_eq("rst_ready", up_ready, 1'b1);

        // Reconstruction: +7, then 1000 with overflow = +8
        send_beat(4'b0111, 1'b0);
        check_eq("rec1_acc", acc, 8'd7);
        check_eq("rec1_dv", down_valid, 1'b1);
        send_beat(4'b1000, 1'b1);
        check_eq("rec2_acc", acc, 8'd15);
        check_eq("rec2_cnt", ovf_cnt, 8'd1);
        check_eq("rec2_sat", acc_sat, 1'b0);
        step();
        check_eq("drain_dv", down_valid, 1'b0);
        check_eq("drain_acc", acc, 8'd15);

        // Negative overflow: 0111 with overflow = -9
        do_clear();
        check_eq("clr_acc", acc, 8'h00);
        check_eq("clr_cnt", ovf_cnt, 8'h00);
        send_beat(4'b0111, 1'b1);
        check_eq("neg_acc", acc, 8'hF7);
        check_eq("neg_cnt", ovf_cnt, 8'd1);

        // Limit: 16 beats of +8 back to back
        do_clear();
        up_valid    = 1'b1;
        up_sum      = 4'b1000;
        up_overflow = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check_eq("sat15_acc", acc, 8'd120);
        check_eq("sat15_flag", acc_sat, 1'b0);
        check_eq("sat15_sticky", sticky_ovf, 1'b0);
        step();
        check_eq("sat16_acc", acc, exp_wrap16);
        check_eq("sat16_flag", acc_sat, 1'b1);
        check_eq("sat16_sticky", sticky_ovf, 1'b1);
        check_eq("sat16_cnt", ovf_cnt, 8'd16);
        up_sum      = 4'b0000;
        up_overflow = 1'b0;
        step();
        up_valid = 1'b0;
        check_eq("sat17_acc", acc, exp_wrap16);
        check_eq("sat17_flag", acc_sat, 1'b0);
        check_eq("sat17_sticky", sticky_ovf, 1'b1);

        // Backpressure
        do_clear();
        send_beat(4'b0011, 1'b0);
        check_eq("bp_first", acc, 8'd3);
        down_ready  = 1'b0;
        up_valid    = 1'b1;
        up_sum      = 4'b0010;
        up_overflow = 1'b0;
        #1;
        check_eq("bp_ready0", up_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_hold_acc", acc, 8'd3);
            check_eq("bp_hold_dv", down_valid, 1'b1);
            check_eq("bp_hold_rdy", up_ready, 1'b0);
        end
        down_ready = 1'b1;
        #1;
        check_eq("bp_release_rdy", up_ready, 1'b1);
        step();
        up_valid = 1'b0;
        check_eq("bp_after_acc", acc, 8'd5);
        check_eq("bp_after_dv", down_valid, 1'b1);

        // Clear collision at acc=50
        do_clear();
        up_valid    = 1'b1;
        up_sum      = 4'b1000;
        up_overflow = 1'b1;
        step();
        up_sum      = 4'b0111;
        up_overflow = 1'b0;
        for (int i = 0; i < 6; i++) step();
        up_valid = 1'b0;
        check_eq("cc_pre_acc", acc, 8'd50);
        check_eq("cc_pre_cnt", ovf_cnt, 8'd1);
        up_valid    = 1'b1;
        up_sum      = 4'b0011;
        up_overflow = 1'b0;
        clear       = 1'b1;
        #1;
        check_eq("cc_ready", up_ready, 1'b1);
        step();
        clear    = 1'b0;
        up_valid = 1'b0;
        check_eq("cc_acc", acc, 8'h00);
        check_eq("cc_cnt", ovf_cnt, 8'h00);
        check_eq("cc_sticky", sticky_ovf, 1'b0);
        check_eq("cc_dv", down_valid, 1'b0);

        // Reset mid-handshake
        down_ready = 1'b0;
        send_beat(4'b0101, 1'b1);
        check_eq("mr_pre_acc", acc, 8'hF5);
        check_eq("mr_pre_dv", down_valid, 1'b1);
        up_valid    = 1'b1;
        up_sum      = 4'b0001;
        up_overflow = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mr_acc", acc, 8'h00);
        check_eq("mr_dv", down_valid, 1'b0);
        check_eq("mr_cnt", ovf_cnt, 8'h00);
        check_eq("mr_sticky", sticky_ovf, 1'b0);
        up_valid   = 1'b0;
        down_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        step();
        check_eq("mr_ready", up_ready, 1'b1);
        check_eq("mr_post_dv", down_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
